// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and the init command table for the
// HD44780 character-LCD writer.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam int LCD_COLS  = 16;
  localparam int MAX_CHARS = 32;
  localparam int WAIT_W    = 20;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    IDLE,
    CLEAR,
    CHAR,
    LINE2,
    DONE
  } main_state_e;

  typedef enum logic [1:0] {
    SETUP,
    PULSE,
    HOLD
  } byte_state_e;

  // Power-up command sequence, indexed by step 0..3.
  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_hd44780_writer_if.sv
// Host-side port bundle of the LCD writer: buffer fill, frame request and
// the ready/done handshake back to the formatter.
interface lcd_hd44780_writer_if;

  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic [5:0] len;
  logic       ready;
  logic       done;

  modport master (
    output wr_en, wr_addr, wr_data, start, len,
    input  ready, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, len,
    output ready, done
  );

endinterface

// File: rtl/lcd_hd44780_writer_byte_tx.sv
// Sends one byte on the HD44780 bus: setup cycle, enable pulse, then a hold
// wait whose length depends on whether the byte is the slow clear command.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int T_EN  = 12,
  parameter int T_CMD = 2500,
  parameter int T_CLR = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       tx_done
);

  localparam logic [WAIT_W-1:0] EN_LAST  = WAIT_W'(T_EN - 1);
  localparam logic [WAIT_W-1:0] CMD_LAST = WAIT_W'(T_CMD - 1);
  localparam logic [WAIT_W-1:0] CLR_LAST = WAIT_W'(T_CLR - 1);

  byte_state_e       state_q, state_d;
  logic              active_q, active_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              rs_q, rs_d;
  logic [7:0]        data_q, data_d;
  logic              e_q, e_d;
  logic [WAIT_W-1:0] hold_last;

  assign hold_last = (!rs_q && data_q == CMD_CLEAR) ? CLR_LAST : CMD_LAST;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    rs_d     = rs_q;
    data_d   = data_q;
    e_d      = 1'b0;
    tx_done  = 1'b0;

    if (active_q) begin
      case (state_q)
        SETUP: begin
          state_d = PULSE;
          cnt_d   = '0;
          e_d     = 1'b1;
        end
        PULSE: begin
          if (cnt_q == EN_LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            e_d   = 1'b1;
          end
        end
        default: begin
          if (cnt_q == hold_last) begin
            tx_done  = 1'b1;
            active_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end

    // A new byte may be queued on the final hold cycle so bytes run back to back.
    if (go && (!active_q || tx_done)) begin
      active_d = 1'b1;
      state_d  = SETUP;
      cnt_d    = '0;
      rs_d     = rs;
      data_d   = data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SETUP;
      active_q <= 1'b0;
      cnt_q    <= '0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      e_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
      e_q      <= e_d;
    end
  end

  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;
  assign lcd_e    = e_q;

endmodule

// File: rtl/lcd_hd44780_writer.sv
// 16x2 HD44780 writer: holds a 32-byte character buffer and, on start,
// clears the display and writes up to two lines of it.
module lcd_hd44780_writer
  import lcd_pkg::*;
#(
  parameter int T_PWRUP = 1000000,
  parameter int T_EN    = 12,
  parameter int T_CMD   = 2500,
  parameter int T_CLR   = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  lcd_hd44780_writer_if.slave        host,
  output logic                       lcd_rs,
  output logic                       lcd_rw,
  output logic                       lcd_e,
  output logic [7:0]                 lcd_data
);

  localparam logic [WAIT_W-1:0] PWRUP_LAST = WAIT_W'(T_PWRUP - 1);
  localparam logic [5:0]        MAX_LEN    = 6'(MAX_CHARS);
  localparam logic [5:0]        LINE_LEN   = 6'(LCD_COLS);

  main_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        init_step_q, init_step_d;
  logic [5:0]        idx_q, idx_d;
  logic [5:0]        len_q, len_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [5:0]        idx_next;

  logic              go;
  logic              tx_rs;
  logic [7:0]        tx_data;
  logic              tx_done;

  logic [7:0]        buf_q [MAX_CHARS];

  // NOTE: the character buffer is plain storage with no reset; its contents
  // are only meaningful once the formatter has written them.
  always_ff @(posedge clk) begin
    if (host.wr_en && ready_q) buf_q[host.wr_addr] <= host.wr_data;
  end

  assign idx_next = idx_q + 6'd1;

  // The next byte is chosen on the cycle its predecessor finishes, so the
  // byte engine can start it without a gap.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    init_step_d = init_step_q;
    idx_d       = idx_q;
    len_d       = len_q;
    go          = 1'b0;
    tx_rs       = 1'b0;
    tx_data     = 8'h00;

    case (state_q)
      PWRUP: begin
        if (wait_q == PWRUP_LAST) begin
          state_d     = INIT;
          init_step_d = 2'd0;
          go          = 1'b1;
          tx_data     = init_cmd(2'd0);
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      INIT: begin
        if (tx_done) begin
          if (init_step_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            init_step_d = init_step_q + 2'd1;
            go          = 1'b1;
            tx_data     = init_cmd(init_step_q + 2'd1);
          end
        end
      end
      IDLE: begin
        if (host.start) begin
          len_d   = (host.len > MAX_LEN) ? MAX_LEN : host.len;
          idx_d   = '0;
          state_d = CLEAR;
          go      = 1'b1;
          tx_data = CMD_CLEAR;
        end
      end
      CLEAR: begin
        if (tx_done) begin
          if (len_q != '0) begin
            state_d = CHAR;
            go      = 1'b1;
            tx_rs   = 1'b1;
            tx_data = buf_q[0];
          end else begin
            state_d = DONE;
          end
        end
      end
      CHAR: begin
        if (tx_done) begin
          idx_d = idx_next;
          if (idx_next == len_q) begin
            state_d = DONE;
          end else if (idx_next == LINE_LEN) begin
            state_d = LINE2;
            go      = 1'b1;
            tx_data = CMD_LINE2;
          end else begin
            go      = 1'b1;
            tx_rs   = 1'b1;
            tx_data = buf_q[idx_next[4:0]];
          end
        end
      end
      LINE2: begin
        if (tx_done) begin
          state_d = CHAR;
          go      = 1'b1;
          tx_rs   = 1'b1;
          tx_data = buf_q[idx_q[4:0]];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = PWRUP;
    endcase

    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWRUP;
      wait_q      <= '0;
      init_step_q <= 2'd0;
      idx_q       <= '0;
      len_q       <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      init_step_q <= init_step_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  assign host.ready = ready_q;
  assign host.done  = done_q;
  assign lcd_rw     = 1'b0;

  lcd_byte_tx #(
    .T_EN  (T_EN),
    .T_CMD (T_CMD),
    .T_CLR (T_CLR)
  ) u_byte_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .rs       (tx_rs),
    .data     (tx_data),
    .lcd_rs   (lcd_rs),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data),
    .tx_done  (tx_done)
  );

endmodule
